// File: rtl/ibex_tlul_host_arb.sv
// Merges the Ibex instruction (h0) and data (h1) TL-UL host ports onto one xbar host link.
// Define IBEX_TLUL_HOST_ARB_STATS_EN to add saturating per-host A-handshake counters.
module ibex_tlul_host_arb #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // h2d: {a_valid, a_opcode[2:0], a_param[2:0], a_size[1:0], a_source[7:0],
  //       a_address[31:0], a_mask[3:0], a_data[31:0], d_ready}
  input  logic [85:0] tl_h0_i,
  // d2h: {d_valid, d_opcode[2:0], d_param[2:0], d_size[1:0], d_source[7:0],
  //       d_sink, d_data[31:0], d_error, a_ready}
  output logic [51:0] tl_h0_o,
  input  logic [85:0] tl_h1_i,
  output logic [51:0] tl_h1_o,
  output logic [85:0] tl_o,
  input  logic [51:0] tl_i,
  output logic        err_o
`ifdef IBEX_TLUL_HOST_ARB_STATS_EN
  ,
  output logic [15:0] stat_h0_o,
  output logic [15:0] stat_h1_o
`endif
);

  localparam int unsigned TL_AIW = 8;
  localparam int unsigned A_LO_W = 32 + 4 + 32;
  localparam int unsigned D_LO_W = 1 + 32 + 1;
  localparam int unsigned CW     = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MaxOutstanding);

  logic [85:0]        h_req      [2];
  logic [51:0]        h_rsp      [2];
  logic [7:0]         h_a_hi     [2];
  logic [TL_AIW-1:0]  h_a_source [2];
  logic [A_LO_W-1:0]  h_a_lo     [2];
  logic [CW-1:0]      host_cnt   [2];
  logic [1:0]         h_a_valid, h_d_ready, h_a_ready, h_d_valid;
  logic [1:0]         eligible, src_bad, d_hs;

  logic               x_d_valid, x_a_ready;
  logic [7:0]         x_d_hi;
  logic [TL_AIW-1:0]  x_d_source;
  logic [D_LO_W-1:0]  x_d_lo;

  logic d_host, orphan, arb_sel, sel, a_valid_out, a_hs;
  logic lock_reg, lock_next, sel_reg, last_reg;

  assign h_req[0] = tl_h0_i;
  assign h_req[1] = tl_h1_i;
  assign tl_h0_o  = h_rsp[0];
  assign tl_h1_o  = h_rsp[1];

  assign {x_d_valid, x_d_hi, x_d_source, x_d_lo, x_a_ready} = tl_i;

  // The source MSB names the issuing host; a response for a host with nothing
  // outstanding cannot belong to it and is swallowed.
  assign d_host = x_d_source[TL_AIW-1];
  assign orphan = x_d_valid && (host_cnt[d_host] == '0);

`ifdef IBEX_TLUL_HOST_ARB_STATS_EN
  logic [15:0] host_stat [2];
  assign stat_h0_o = host_stat[0];
  assign stat_h1_o = host_stat[1];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_host
      logic          a_inc;
      logic [CW-1:0] cnt_reg, cnt_next;

      assign {h_a_valid[gi], h_a_hi[gi], h_a_source[gi], h_a_lo[gi], h_d_ready[gi]} = h_req[gi];

      assign eligible[gi]  = h_a_valid[gi] && (cnt_reg < CNT_MAX);
      assign src_bad[gi]   = h_a_valid[gi] && h_a_source[gi][TL_AIW-1];
      assign h_a_ready[gi] = x_a_ready && a_valid_out && (sel == 1'(gi));
      assign h_d_valid[gi] = x_d_valid && !orphan && (d_host == 1'(gi));
      assign d_hs[gi]      = h_d_valid[gi] && h_d_ready[gi];

      assign h_rsp[gi] = {h_d_valid[gi], x_d_hi, 1'b0, x_d_source[TL_AIW-2:0],
                          x_d_lo, h_a_ready[gi]};

      // A and D handshakes in the same cycle cancel; eligibility and the orphan
      // filter keep the counter inside 0..MaxOutstanding.
      assign a_inc    = a_hs && (sel == 1'(gi));
      assign cnt_next = (a_inc && !d_hs[gi]) ? cnt_reg + CW'(1) :
                        (!a_inc && d_hs[gi]) ? cnt_reg - CW'(1) : cnt_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign host_cnt[gi] = cnt_reg;

`ifdef IBEX_TLUL_HOST_ARB_STATS_EN
      logic [15:0] stat_reg;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          stat_reg <= '0;
        end else if (a_inc && (stat_reg != 16'hFFFF)) begin
          stat_reg <= stat_reg + 16'd1;
        end
      end
      assign host_stat[gi] = stat_reg;
`endif
    end
  endgenerate

  always_comb begin
    arb_sel = 1'b0;
    if (eligible == 2'b11) begin
      arb_sel = RoundRobin ? !last_reg : 1'b1;
    end else if (eligible[1]) begin
      arb_sel = 1'b1;
    end
  end

  // A stalled request keeps its grant so the A channel stays stable.
  assign sel         = lock_reg ? sel_reg : arb_sel;
  assign a_valid_out = eligible[sel];
  assign a_hs        = a_valid_out && x_a_ready;
  assign lock_next   = a_valid_out && !x_a_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_reg <= 1'b0;
      sel_reg  <= 1'b0;
      last_reg <= 1'b1;
    end else begin
      lock_reg <= lock_next;
      if (lock_next) begin
        sel_reg <= sel;
      end
      if (a_hs) begin
        last_reg <= sel;
      end
    end
  end

  assign tl_o = {a_valid_out, h_a_hi[sel], sel, h_a_source[sel][TL_AIW-2:0],
                 h_a_lo[sel], orphan || h_d_ready[d_host]};

  assign err_o = (|src_bad) || orphan;

endmodule

// File: tb/tb_ibex_tlul_host_arb.sv
// Bench for ibex_tlul_host_arb: cycle vector table for the corner cases, then
// randomized two-host traffic checked end to end against a response scoreboard.
module tb_ibex_tlul_host_arb;

  localparam int          NREQ = 12;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;

  logic        clk;
  logic        rst_ni;
  logic [85:0] tl_h0_i, tl_h1_i, tl_o;
  logic [51:0] tl_h0_o, tl_h1_o, tl_i;
  logic        err_o;
`ifdef IBEX_TLUL_HOST_ARB_STATS_EN
  logic [15:0] stat_h0, stat_h1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ibex_tlul_host_arb #(.MaxOutstanding(2), .RoundRobin(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .tl_h0_i (tl_h0_i),
    .tl_h0_o (tl_h0_o),
    .tl_h1_i (tl_h1_i),
    .tl_h1_o (tl_h1_o),
    .tl_o    (tl_o),
    .tl_i    (tl_i),
    .err_o   (err_o)
`ifdef IBEX_TLUL_HOST_ARB_STATS_EN
    ,
    .stat_h0_o (stat_h0),
    .stat_h1_o (stat_h1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [85:0] mk_h2d(input logic v, input logic [7:0] src,
                                         input logic [31:0] addr, input logic dr);
    return {v, 3'd4, 3'd0, 2'd2, src, addr, 4'hF, 32'h0, dr};
  endfunction

  function automatic logic [51:0] mk_d2h(input logic dv, input logic [7:0] src,
                                         input logic [31:0] data, input logic ar);
    return {dv, 3'd1, 3'd0, 2'd2, src, 1'b0, data, 1'b0, ar};
  endfunction

  function automatic logic [51:0] host_rsp(input int x);
    return (x == 0) ? tl_h0_o : tl_h1_o;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    tl_h0_i = mk_h2d(1'b0, 8'h00, 32'h0, 1'b1);
    tl_h1_i = mk_h2d(1'b0, 8'h00, 32'h0, 1'b1);
    tl_i    = mk_d2h(1'b0, 8'h00, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_ni = 1'b0;
    #4;
    chk("rst_a_valid", 0, 32'(tl_o[85]), 0);
    chk("rst_d_ready", 0, 32'(tl_o[0]), 1);
    chk("rst_err", 0, 32'(err_o), 0);
    chk("rst_h0_a_ready", 0, 32'(tl_h0_o[0]), 0);
    chk("rst_h1_a_ready", 0, 32'(tl_h1_o[0]), 0);
    chk("rst_h0_d_valid", 0, 32'(tl_h0_o[51]), 0);
    chk("rst_h1_d_valid", 0, 32'(tl_h1_o[51]), 0);
`ifdef IBEX_TLUL_HOST_ARB_STATS_EN
    chk("rst_stat_h0", 0, 32'(stat_h0), 0);
    chk("rst_stat_h1", 0, 32'(stat_h1), 0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  typedef struct packed {
    logic       rst;
    logic       h0v;  logic [7:0] h0s;
    logic       h1v;  logic [7:0] h1s;
    logic       ar;
    logic       dv;   logic [7:0] ds;
    logic       h0dr; logic       h1dr;
    logic       e_av; logic [7:0] e_src;
    logic       e_h0ar; logic     e_h1ar;
    logic       e_h0dv; logic     e_h1dv;
    logic [7:0] e_hds;
    logic       e_dr; logic       e_err;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  typedef struct packed {
    logic [7:0]  src;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q0[$], exp_q1[$], xbar_q[$];

  logic        pend     [2];
  int          issued   [2];
  int          done_rsp [2];
  logic [31:0] req_addr [2];
  logic [7:0]  req_src  [2];
  logic        hdr      [2];
  logic        ar, d_active;
  rsp_t        d_cur, got, want;
  int          cyc, errs_seen, qsize;

  initial begin
    rst_ni = 1'b0;
    drive_idle();

    // rst h0v h0s h1v h1s ar dv ds h0dr h1dr | av src h0ar h1ar h0dv h1dv hds dr err
    vecs[0]  = '{1,1,8'h05,0,8'h00,1,0,8'h00,1,1, 1,8'h05,1,0,0,0,8'h00,1,0};
    vecs[1]  = '{0,0,8'h00,0,8'h00,1,1,8'h05,1,1, 0,8'h00,0,0,1,0,8'h05,1,0};
    vecs[2]  = '{1,1,8'h01,1,8'h02,1,0,8'h00,1,1, 1,8'h01,1,0,0,0,8'h00,1,0};
    vecs[3]  = '{0,1,8'h01,1,8'h02,1,0,8'h00,1,1, 1,8'h82,0,1,0,0,8'h00,1,0};
    vecs[4]  = '{0,1,8'h01,1,8'h02,1,0,8'h00,1,1, 1,8'h01,1,0,0,0,8'h00,1,0};
    vecs[5]  = '{0,1,8'h01,1,8'h02,1,0,8'h00,1,1, 1,8'h82,0,1,0,0,8'h00,1,0};
    vecs[6]  = '{0,1,8'h01,1,8'h02,1,0,8'h00,1,1, 0,8'h00,0,0,0,0,8'h00,1,0};
    vecs[7]  = '{0,0,8'h00,1,8'h02,1,1,8'h82,1,1, 0,8'h00,0,0,0,1,8'h02,1,0};
    vecs[8]  = '{0,0,8'h00,1,8'h02,1,0,8'h00,1,1, 1,8'h82,0,1,0,0,8'h00,1,0};
    vecs[9]  = '{0,1,8'h01,0,8'h00,1,0,8'h00,1,1, 0,8'h00,0,0,0,0,8'h00,1,0};
    vecs[10] = '{0,0,8'h00,0,8'h00,1,1,8'h01,1,1, 0,8'h00,0,0,1,0,8'h01,1,0};
    vecs[11] = '{0,0,8'h00,0,8'h00,1,1,8'h01,1,1, 0,8'h00,0,0,1,0,8'h01,1,0};
    vecs[12] = '{0,0,8'h00,0,8'h00,1,1,8'h82,1,1, 0,8'h00,0,0,0,1,8'h02,1,0};
    vecs[13] = '{0,0,8'h00,0,8'h00,1,1,8'h82,1,1, 0,8'h00,0,0,0,1,8'h02,1,0};
    vecs[14] = '{0,0,8'h00,0,8'h00,1,1,8'h82,1,0, 0,8'h00,0,0,0,0,8'h00,1,1};
    vecs[15] = '{0,0,8'h00,0,8'h00,1,0,8'h00,1,1, 0,8'h00,0,0,0,0,8'h00,1,0};
    vecs[16] = '{1,1,8'h03,0,8'h00,1,0,8'h00,1,1, 1,8'h03,1,0,0,0,8'h00,1,0};
    vecs[17] = '{0,0,8'h00,0,8'h00,1,1,8'h03,1,1, 0,8'h00,0,0,1,0,8'h03,1,0};
    vecs[18] = '{0,1,8'h03,0,8'h00,0,0,8'h00,1,1, 1,8'h03,0,0,0,0,8'h00,1,0};
    vecs[19] = '{0,1,8'h03,1,8'h04,0,0,8'h00,1,1, 1,8'h03,0,0,0,0,8'h00,1,0};
    vecs[20] = '{0,1,8'h03,1,8'h04,0,0,8'h00,1,1, 1,8'h03,0,0,0,0,8'h00,1,0};
    vecs[21] = '{0,1,8'h03,1,8'h04,1,0,8'h00,1,1, 1,8'h03,1,0,0,0,8'h00,1,0};
    vecs[22] = '{0,1,8'h03,1,8'h04,1,0,8'h00,1,1, 1,8'h84,0,1,0,0,8'h00,1,0};
    vecs[23] = '{0,1,8'h85,0,8'h00,1,0,8'h00,1,1, 1,8'h05,1,0,0,0,8'h00,1,1};
    vecs[24] = '{1,0,8'h00,0,8'h00,1,1,8'h03,1,1, 0,8'h00,0,0,0,0,8'h00,1,1};

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      tl_h0_i = mk_h2d(vecs[i].h0v, vecs[i].h0s, 32'h0000_1000, vecs[i].h0dr);
      tl_h1_i = mk_h2d(vecs[i].h1v, vecs[i].h1s, 32'h0000_2000, vecs[i].h1dr);
      tl_i    = mk_d2h(vecs[i].dv, vecs[i].ds, 32'h0000_D00D, vecs[i].ar);
      #4;
      chk("a_valid", i, 32'(tl_o[85]), 32'(vecs[i].e_av));
      if (vecs[i].e_av) chk("a_source", i, 32'(tl_o[76:69]), 32'(vecs[i].e_src));
      chk("h0_a_ready", i, 32'(tl_h0_o[0]), 32'(vecs[i].e_h0ar));
      chk("h1_a_ready", i, 32'(tl_h1_o[0]), 32'(vecs[i].e_h1ar));
      chk("h0_d_valid", i, 32'(tl_h0_o[51]), 32'(vecs[i].e_h0dv));
      chk("h1_d_valid", i, 32'(tl_h1_o[51]), 32'(vecs[i].e_h1dv));
      if (vecs[i].e_h0dv) chk("h0_d_source", i, 32'(tl_h0_o[42:35]), 32'(vecs[i].e_hds));
      if (vecs[i].e_h1dv) chk("h1_d_source", i, 32'(tl_h1_o[42:35]), 32'(vecs[i].e_hds));
      chk("d_ready", i, 32'(tl_o[0]), 32'(vecs[i].e_dr));
      chk("err", i, 32'(err_o), 32'(vecs[i].e_err));
      $display("vec %0d: a_valid=%0b a_source=%h err=%0b", i, tl_o[85], tl_o[76:69], err_o);
    end

    // Random two-host traffic with a single in-order xbar responder.
    do_reset();
    for (int x = 0; x < 2; x++) begin
      pend[x] = 1'b0; issued[x] = 0; done_rsp[x] = 0;
      req_addr[x] = 32'h0; req_src[x] = 8'h0; hdr[x] = 1'b1;
    end
    d_active = 1'b0; d_cur = '0; cyc = 0; errs_seen = 0;
    while ((done_rsp[0] < NREQ || done_rsp[1] < NREQ) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && issued[x] < NREQ && $urandom_range(0, 2) != 0) begin
          pend[x]     = 1'b1;
          req_src[x]  = 8'(x * 16 + issued[x]);
          req_addr[x] = 32'h4000_0000 + 32'(x * 4096) + 32'(issued[x] * 4);
        end
        hdr[x] = ($urandom_range(0, 3) != 0);
      end
      ar = ($urandom_range(0, 3) != 0);
      if (!d_active && xbar_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        d_active = 1'b1;
        d_cur    = xbar_q.pop_front();
      end
      tl_h0_i = mk_h2d(pend[0], req_src[0], req_addr[0], hdr[0]);
      tl_h1_i = mk_h2d(pend[1], req_src[1], req_addr[1], hdr[1]);
      tl_i    = mk_d2h(d_active, d_cur.src, d_cur.data, ar);
      #4;
      for (int x = 0; x < 2; x++) begin
        if (pend[x] && host_rsp(x)[0]) begin
          qsize = (x == 0) ? exp_q0.size() : exp_q1.size();
          chk("outstanding_cap", x, 32'(qsize < 2), 1);
          chk("fwd_source", x, 32'(tl_o[76:69]), 32'({x[0], req_src[x][6:0]}));
          chk("fwd_address", x, tl_o[68:37], req_addr[x]);
          if (x == 0) exp_q0.push_back('{req_src[x], req_addr[x] ^ KEY});
          else        exp_q1.push_back('{req_src[x], req_addr[x] ^ KEY});
          pend[x] = 1'b0;
          issued[x]++;
        end
      end
      if (tl_o[85] && ar) xbar_q.push_back('{tl_o[76:69], tl_o[68:37] ^ KEY});
      if (d_active && tl_o[0]) d_active = 1'b0;
      for (int x = 0; x < 2; x++) begin
        if (host_rsp(x)[51] && hdr[x]) begin
          got  = '{host_rsp(x)[42:35], host_rsp(x)[33:2]};
          qsize = (x == 0) ? exp_q0.size() : exp_q1.size();
          if (qsize == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp[%0d] got %h expected none", x, got);
          end else begin
            want = (x == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("rsp_source", x, 32'(got.src), 32'(want.src));
            chk("rsp_data", x, got.data, want.data);
            $display("rsp h%0d: src=%h data=%h", x, got.src, got.data);
          end
          done_rsp[x]++;
        end
      end
      if (err_o) errs_seen++;
    end
    chk("sb_done_h0", 0, 32'(done_rsp[0]), NREQ);
    chk("sb_done_h1", 1, 32'(done_rsp[1]), NREQ);
    chk("sb_err_pulses", 0, 32'(errs_seen), 0);
`ifdef IBEX_TLUL_HOST_ARB_STATS_EN
    chk("stat_h0", 0, 32'(stat_h0), NREQ);
    chk("stat_h1", 1, 32'(stat_h1), NREQ);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
